// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-access stage and its lane aligner.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Access size encodings carried on MemSize; 2'b11 is reserved and behaves as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // One MEM/WB result slot.
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memtoreg;
    logic              misalign;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wreg;
  } result_t;

  // Natural alignment: bytes anywhere, halves on even addresses, words on multiples of 4.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~offset[0];
      default: ok = (offset == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for stores and lane extraction / extension for loads.
// Purely combinational; the store side and load side are independent.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]        st_size,
  input  logic [1:0]        st_offset,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        ld_offset,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] ld_shift;

  // Store: enable the addressed lanes and replicate the data across all of them.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << st_offset;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load: bring the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    ld_shift = ld_rdata >> {ld_offset, 3'b000};
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory-access stage: issues req/ack data-memory accesses and registers
// results toward MEM/WB. Optional MEM_TIMEOUT_EN adds a wait timeout with bus_err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access outstanding; accepts a new instruction each cycle
// ST_REQ  | mem_req held with stable address/data until mem_ack (or timeout)
//
// A pass-through result accepted on the ack cycle cannot share the output
// register with the access being completed, so it waits one cycle in pend_q.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              valid_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [REG_W-1:0]  WriteReg,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_out,
  output logic              RegWrite_out,
  output logic              MemtoReg_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [REG_W-1:0]  WriteReg_out,
`ifdef MEM_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              misalign
);

  state_e            state_q, state_d;
  result_t           out_q, out_d, pend_q, pend_d, new_res, done_res;

  logic              op_load_q, op_load_d;
  logic [1:0]        op_size_q, op_size_d;
  logic              op_signed_q, op_signed_d;
  logic [1:0]        op_off_q, op_off_d;
  logic              op_rw_q, op_rw_d;
  logic              op_mtr_q, op_mtr_d;
  logic [DATA_W-1:0] op_alu_q, op_alu_d;
  logic [REG_W-1:0]  op_wreg_q, op_wreg_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [3:0]        st_be;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic              ack_fire, timeout_fire, done, accept, is_mem, aligned, start_req;

  mem_lane_align u_align (
    .st_size   (MemSize),
    .st_offset (ALUResult[1:0]),
    .st_data   (WriteData),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_size   (op_size_q),
    .ld_signed (op_signed_q),
    .ld_offset (op_off_q),
    .ld_rdata  (mem_rdata),
    .ld_data   (ld_data)
  );

  assign Stall     = (state_q == ST_REQ) & ~mem_ack;
  assign ack_fire  = (state_q == ST_REQ) & mem_ack;
  assign done      = ack_fire | timeout_fire;
  assign accept    = valid_in & ~Stall;
  assign is_mem    = MemRead | MemWrite;
  assign aligned   = is_aligned(MemSize, ALUResult[1:0]);
  assign start_req = accept & is_mem & aligned;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q;

  assign timeout_fire = (state_q == ST_REQ) & ~mem_ack & ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));
  assign bus_err      = bus_err_q;

  // Wait counter: cleared on entry to REQ, counts REQ cycles without ack.
  always_comb begin
    cnt_d = cnt_q;
    if (start_req) begin
      cnt_d = '0;
    end else if ((state_q == ST_REQ) && !mem_ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timeout counter and bus_err pulse registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= timeout_fire;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Result of an instruction completing without a memory access (ALU op or misaligned drop).
  always_comb begin
    new_res.valid    = accept & ~(is_mem & aligned);
    new_res.regwrite = is_mem ? 1'b0 : RegWrite_in;
    new_res.memtoreg = is_mem ? 1'b0 : MemtoReg_in;
    new_res.misalign = is_mem & ~aligned;
    new_res.rdata    = '0;
    new_res.alu      = ALUResult;
    new_res.wreg     = WriteReg;
  end

  // Result of the outstanding access, either acked or timed out.
  always_comb begin
    done_res.valid    = 1'b1;
    done_res.regwrite = ack_fire & op_rw_q;
    done_res.memtoreg = ack_fire & op_mtr_q;
    done_res.misalign = 1'b0;
    done_res.rdata    = (ack_fire & op_load_q) ? ld_data : '0;
    done_res.alu      = op_alu_q;
    done_res.wreg     = op_wreg_q;
  end

  // Next state, output-slot arbitration and request latching.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_d.valid = 1'b0;
    out_d.misalign = 1'b0;
    pend_d      = pend_q;
    op_load_d   = op_load_q;
    op_size_d   = op_size_q;
    op_signed_d = op_signed_q;
    op_off_d    = op_off_q;
    op_rw_d     = op_rw_q;
    op_mtr_d    = op_mtr_q;
    op_alu_d    = op_alu_q;
    op_wreg_d   = op_wreg_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    if (done) begin
      out_d  = done_res;
      pend_d = new_res;
    end else if (pend_q.valid) begin
      out_d  = pend_q;
      pend_d = new_res;
    end else begin
      pend_d.valid = 1'b0;
      if (new_res.valid) out_d = new_res;
    end

    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_REQ;
      ST_REQ:  if (!start_req && done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start_req) begin
      op_load_d   = ~MemWrite;
      op_size_d   = MemSize;
      op_signed_d = MemSigned;
      op_off_d    = ALUResult[1:0];
      op_rw_d     = RegWrite_in;
      op_mtr_d    = MemtoReg_in;
      op_alu_d    = ALUResult;
      op_wreg_d   = WriteReg;
      mem_req_d   = 1'b1;
      mem_we_d    = MemWrite;
      mem_addr_d  = {ALUResult[DATA_W-1:2], 2'b00};
      mem_be_d    = st_be;
      mem_wdata_d = st_wdata;
    end else if (done) begin
      mem_req_d   = 1'b0;
    end
  end

  // State, result and memory-port registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      pend_q      <= '0;
      op_load_q   <= 1'b0;
      op_size_q   <= 2'b00;
      op_signed_q <= 1'b0;
      op_off_q    <= 2'b00;
      op_rw_q     <= 1'b0;
      op_mtr_q    <= 1'b0;
      op_alu_q    <= '0;
      op_wreg_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      pend_q      <= pend_d;
      op_load_q   <= op_load_d;
      op_size_q   <= op_size_d;
      op_signed_q <= op_signed_d;
      op_off_q    <= op_off_d;
      op_rw_q     <= op_rw_d;
      op_mtr_q    <= op_mtr_d;
      op_alu_q    <= op_alu_d;
      op_wreg_q   <= op_wreg_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign valid_out     = out_q.valid;
  assign RegWrite_out  = out_q.regwrite;
  assign MemtoReg_out  = out_q.memtoreg;
  assign ReadData_out  = out_q.rdata;
  assign ALUResult_out = out_q.alu;
  assign WriteReg_out  = out_q.wreg;
  assign misalign      = out_q.misalign;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: a driver pushes expected requests and
// results in program order, a memory model checks/answers requests, and a
// monitor pops and compares every valid_out. Build with MEM_TIMEOUT_EN to add
// the timeout scenario.
module tb_mem_stage_ctrl;

  logic        Clk, Rst_n;
  logic        valid_in, RegWrite_in, MemtoReg_in, MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] ALUResult, WriteData, mem_rdata;
  logic [4:0]  WriteReg;
  logic        mem_ack;
  logic        Stall, mem_req, mem_we, valid_out, RegWrite_out, MemtoReg_out, misalign;
  logic [31:0] mem_addr, mem_wdata, ReadData_out, ALUResult_out;
  logic [3:0]  mem_be;
  logic [4:0]  WriteReg_out;
`ifdef MEM_TIMEOUT_EN
  logic        bus_err;
`endif

  typedef struct {
    logic        rw, mtr, mis, berr;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
  } req_t;

  res_t res_q[$];
  req_t req_q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_vo_cyc = 0, prev_vo_cyc = 0;
  int   forced_lat = -1;
  bit   mem_en = 1, force_ack = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .valid_in(valid_in), .RegWrite_in(RegWrite_in),
    .MemtoReg_in(MemtoReg_in), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemSigned(MemSigned), .ALUResult(ALUResult), .WriteData(WriteData), .WriteReg(WriteReg),
    .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_out(valid_out),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .ReadData_out(ReadData_out),
    .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out),
`ifdef MEM_TIMEOUT_EN
    .bus_err(bus_err),
`endif
    .misalign(misalign)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: derive the request and the MEM/WB result from the access rules.
  task automatic push_instr(input logic rw, mtr, rd, wr, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] alu, wd, input logic [4:0] wreg,
                            input logic [31:0] rdata);
    int nb, off;
    res_t r;
    req_t q;
    logic [31:0] w;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(alu[1:0]);
    r = '{rw: rw, mtr: mtr, mis: 1'b0, berr: 1'b0, rd: 32'h0, alu: alu, wr: wreg};
    if (!(rd || wr)) begin
      res_q.push_back(r);
    end else if ((off % nb) != 0) begin
      r.rw = 1'b0; r.mtr = 1'b0; r.mis = 1'b1;
      res_q.push_back(r);
    end else begin
      q.we = wr; q.addr = alu & 32'hFFFF_FFFC; q.be = 4'b0; q.wdata = 32'h0; q.rdata = rdata;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nb) q.be[i] = 1'b1;
        q.wdata = q.wdata | (((wd >> (8 * (i % nb))) & 32'hFF) << (8 * i));
      end
      if (!wr) begin
        w = rdata >> (8 * off);
        if (nb == 1) begin
          w = w & 32'hFF;
          if (sgn && w[7]) w = w | 32'hFFFF_FF00;
        end else if (nb == 2) begin
          w = w & 32'hFFFF;
          if (sgn && w[15]) w = w | 32'hFFFF_0000;
        end
        r.rd = w;
      end
      req_q.push_back(q);
      res_q.push_back(r);
    end
  endtask

  // Present one instruction (or a bubble) and hold it until it is accepted.
  task automatic drive(input logic v, rw, mtr, rd, wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] alu, wd, input logic [4:0] wreg, output int stalls);
    @(negedge Clk);
    valid_in = v; RegWrite_in = rw; MemtoReg_in = mtr; MemRead = rd; MemWrite = wr;
    MemSize = sz; MemSigned = sgn; ALUResult = alu; WriteData = wd; WriteReg = wreg;
    #1;
    stalls = 0;
    while (v && Stall && stalls < 200) begin
      @(negedge Clk);
      #1;
      stalls++;
    end
    if (stalls >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL stall_bound: Stall still 1 after %0d cycles, required 0", stalls);
    end
  endtask

  task automatic issue(input logic rw, mtr, rd, wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] alu, wd, input logic [4:0] wreg,
                       input logic [31:0] rdata, output int stalls);
    push_instr(rw, mtr, rd, wr, sz, sgn, alu, wd, wreg, rdata);
    drive(1'b1, rw, mtr, rd, wr, sz, sgn, alu, wd, wreg, stalls);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      valid_in = 1'b0;
    end
  endtask

  // Monitor: every valid_out must match the oldest expected result.
  res_t mon_e;
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (valid_out) begin
        prev_vo_cyc = last_vo_cyc;
        last_vo_cyc = cyc;
        if (res_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid_out: got valid_out=1 alu=0x%08h, required no result", ALUResult_out);
        end else begin
          mon_e = res_q.pop_front();
          chk("res_regwrite", 32'(RegWrite_out), 32'(mon_e.rw));
          chk("res_memtoreg", 32'(MemtoReg_out), 32'(mon_e.mtr));
          chk("res_misalign", 32'(misalign), 32'(mon_e.mis));
          chk("res_readdata", ReadData_out, mon_e.rd);
          chk("res_aluresult", ALUResult_out, mon_e.alu);
          chk("res_writereg", 32'(WriteReg_out), 32'(mon_e.wr));
`ifdef MEM_TIMEOUT_EN
          chk("res_bus_err", 32'(bus_err), 32'(mon_e.berr));
`endif
        end
      end else if (misalign) begin
        chk("misalign_without_valid", 32'(misalign), 32'h0);
      end
    end
  end

  // Memory model: checks each request (every cycle it is held) and acks after a latency.
  initial begin
    int   lat;
    bit   known;
    req_t cur;
    lat = -1; known = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, be: 4'h0};
    forever begin
      @(negedge Clk);
      mem_ack = force_ack;
      mem_rdata = $urandom;
      if (!mem_en || !Rst_n || !mem_req) begin
        lat = -1;
      end else begin
        if (lat < 0) begin
          if (req_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_mem_req: got request addr=0x%08h, required none", mem_addr);
            known = 1'b0;
            lat = 0;
          end else begin
            cur = req_q.pop_front();
            known = 1'b1;
            lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
          end
        end
        if (known) begin
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_be", 32'(mem_be), 32'(cur.be));
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        end
        if (lat == 0) begin
          mem_ack = 1'b1;
          mem_rdata = cur.rdata;
          lat = -1;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic v, rw, mtr, rd, wr, sgn;
    logic [1:0] sz;
    logic [31:0] alu;
    int kind;

    Rst_n = 1'b0; valid_in = 1'b0; RegWrite_in = 1'b0; MemtoReg_in = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSigned = 1'b0;
    ALUResult = 32'h0; WriteData = 32'h0; WriteReg = 5'd0;
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_outputs_zero", 32'(|{Stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, valid_out,
        RegWrite_out, MemtoReg_out, ReadData_out, ALUResult_out, WriteReg_out, misalign}), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Non-memory pass-through.
    issue(1, 0, 0, 0, 2'b10, 0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, st);
    @(negedge Clk);
    valid_in = 1'b0;
    #1;
    chk("passthru_valid", 32'(valid_out), 32'h1);
    chk("passthru_no_req", 32'(mem_req), 32'h0);
    chk("passthru_no_stall", 32'(Stall), 32'h0);
    idle(2);

    // Signed byte load with 3-cycle wait, ALU op presented back-to-back.
    forced_lat = 3;
    issue(1, 1, 1, 0, 2'b00, 1, 32'h0000_0103, 32'h1111_2222, 5'd7, 32'h80FF_0011, st);
    issue(1, 0, 0, 0, 2'b10, 0, 32'h0000_0ABC, 32'h0, 5'd9, 32'h0, st);
    chk("stall_cycles_lat3", st, 3);
    idle(4);
    chk("b2b_consecutive", last_vo_cyc - prev_vo_cyc, 1);

    // Unsigned variant, half store, misaligned word load, reserved size, read+write.
    forced_lat = 1;
    issue(1, 1, 1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 5'd8, 32'h80FF_0011, st);
    idle(4);
    forced_lat = 2;
    issue(0, 0, 0, 1, 2'b01, 0, 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 32'h0, st);
    idle(5);
    issue(1, 1, 1, 0, 2'b10, 0, 32'h0000_0301, 32'h0, 5'd4, 32'h0, st);
    @(negedge Clk);
    valid_in = 1'b0;
    #1;
    chk("misalign_no_req", 32'(mem_req), 32'h0);
    idle(2);
    issue(1, 0, 1, 0, 2'b11, 1, 32'h0000_0408, 32'h0, 5'd6, 32'hCAFE_F00D, st);
    idle(3);
    issue(0, 0, 1, 1, 2'b00, 0, 32'h0000_0501, 32'h0000_00A5, 5'd2, 32'h0, st);
    idle(4);

    // Randomized traffic with random latencies and bubbles.
    forced_lat = -1;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      kind = int'($urandom_range(0, 3));
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      rw = 1'($urandom); mtr = 1'($urandom); sgn = 1'($urandom); sz = 2'($urandom);
      alu = ($urandom_range(0, 1) != 0) ? $urandom : (32'($urandom_range(0, 255)) << 2 | 32'($urandom_range(0, 3)));
      if (v) issue(rw, mtr, rd, wr, sz, sgn, alu, $urandom, 5'($urandom), $urandom, st);
      else idle(1);
    end
    idle(6);
    chk("random_drained", res_q.size(), 0);

    // Reset while a request is outstanding; later acks must be ignored.
    mem_en = 1'b0;
    issue(1, 1, 1, 0, 2'b10, 0, 32'h0000_0400, 32'h0, 5'd1, 32'h1234_5678, st);
    idle(2);
    chk("req_before_reset", 32'(mem_req), 32'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("reset_drops_req", 32'(mem_req), 32'h0);
    chk("reset_drops_stall", 32'(Stall), 32'h0);
    chk("reset_all_zero", 32'(|{mem_we, mem_addr, mem_be, mem_wdata, valid_out, RegWrite_out,
        MemtoReg_out, ReadData_out, ALUResult_out, WriteReg_out, misalign}), 32'h0);
    res_q.delete();
    req_q.delete();
    force_ack = 1'b1;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    mem_en = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      #1;
      chk("late_ack_ignored", 32'(valid_out), 32'h0);
    end
    force_ack = 1'b0;
    issue(1, 0, 0, 0, 2'b10, 0, 32'h0000_7777, 32'h0, 5'd11, 32'h0, st);
    idle(3);

`ifdef MEM_TIMEOUT_EN
    // Never-acked load times out after 4 REQ cycles.
    mem_en = 1'b0;
    res_q.push_back('{rw: 1'b0, mtr: 1'b0, mis: 1'b0, berr: 1'b1, rd: 32'h0, alu: 32'h0000_0600, wr: 5'd12});
    drive(1, 1, 1, 1, 0, 2'b10, 0, 32'h0000_0600, 32'h0, 5'd12, st);
    push_instr(1, 0, 0, 0, 2'b10, 0, 32'h0000_0601, 32'h0, 5'd13, 32'h0);
    drive(1, 1, 0, 0, 0, 2'b10, 0, 32'h0000_0601, 32'h0, 5'd13, st);
    chk("timeout_stall_cycles", st, 4);
    idle(3);
    force_ack = 1'b1;
    idle(2);
    force_ack = 1'b0;
    mem_en = 1'b1;
    idle(2);
`endif

    idle(5);
    chk("results_drained", res_q.size(), 0);
    chk("requests_drained", req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
